// File: rtl/flood_sequencer.sv
// flood_sequencer: recolours the flooded region and sweeps the board to absorb matching neighbours
module flood_sequencer #(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               INIT,
  input  logic               START,
  input  logic [COLOR_W-1:0] COLOR,
  input  logic [4:0]         SIZE,
  output logic [9:0]         CELL_ADDR,
  input  logic [COLOR_W-1:0] CELL_RDATA,
  output logic               CELL_WE,
  output logic [COLOR_W-1:0] CELL_WDATA,
  output logic               BUSY,
  output logic               DONE,
  output logic               GROWN,
  output logic               WON,
  output logic [9:0]         FLOOD_COUNT
);
  typedef enum logic [2:0] {IDLE, SEED, RECOLOR, GROW_ADDR, GROW_EVAL, SWEEP_END, FINISH} state_t;
  localparam logic [4:0] MAXS = 5'(MAX_SIZE);
  localparam logic [9:0] CMAX = 10'(MAX_SIZE * MAX_SIZE);
  state_t state, state_nx;
  logic [MAX_SIZE-1:0][MAX_SIZE-1:0] mask;
  logic [4:0] r, c, sz, sz_in;
  logic [COLOR_W-1:0] regc;
  logic [9:0] count, old_count, area;
  logic changed, is_move, grown_q, won_q;
  logic last_col, last_cell, nbr, take, step, grown_now, won_now;
  // Scan position, neighbour test and clamped board edge
  always_comb begin
    sz_in     = SIZE < 5'd2 ? 5'd2 : SIZE > MAXS ? MAXS : SIZE;
    last_col  = c == sz - 5'd1;
    last_cell = last_col && r == sz - 5'd1;
    step      = state == RECOLOR || state == GROW_EVAL;
    nbr       = (r != 5'd0 && mask[r - 5'd1][c]) || (r != sz - 5'd1 && mask[r + 5'd1][c]) ||
                (c != 5'd0 && mask[r][c - 5'd1]) || (c != sz - 5'd1 && mask[r][c + 5'd1]);
    take      = state == GROW_EVAL && !mask[r][c] && CELL_RDATA == regc && nbr;
    area      = {5'd0, sz} * {5'd0, sz};
    grown_now = is_move && count > old_count;
    won_now   = count == area;
  end
  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = INIT ? SEED : START ? (COLOR == regc ? FINISH : RECOLOR) : IDLE;
      SEED:      state_nx = GROW_ADDR;
      RECOLOR:   state_nx = last_cell ? GROW_ADDR : RECOLOR;
      GROW_ADDR: state_nx = GROW_EVAL;
      GROW_EVAL: state_nx = last_cell ? SWEEP_END : GROW_ADDR;
      SWEEP_END: state_nx = changed ? GROW_ADDR : FINISH;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  // Outputs; GROWN and WON show the fresh result during the DONE cycle, then hold it
  always_comb begin
    CELL_ADDR   = {r, c};
    CELL_WE     = state == RECOLOR && mask[r][c];
    CELL_WDATA  = regc;
    BUSY        = state != IDLE && state != FINISH;
    DONE        = state == FINISH;
    GROWN       = DONE ? grown_now : grown_q;
    WON         = DONE ? won_now : won_q;
    FLOOD_COUNT = count;
  end
  // State, scan counters, mask and bookkeeping
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      mask      <= '0;
      r         <= '0;
      c         <= '0;
      sz        <= 5'd2;
      regc      <= '0;
      count     <= '0;
      old_count <= '0;
      changed   <= 1'b0;
      is_move   <= 1'b0;
      grown_q   <= 1'b0;
      won_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (step) begin
        c <= last_col ? 5'd0 : c + 5'd1;
        r <= last_cell ? 5'd0 : last_col ? r + 5'd1 : r;
      end
      if (state == IDLE && INIT) begin
        mask       <= '0;
        mask[0][0] <= 1'b1;
        count      <= 10'd1;
        sz         <= sz_in;
        is_move    <= 1'b0;
      end else if (state == IDLE && START) begin
        sz        <= sz_in;
        old_count <= count;
        is_move   <= 1'b1;
        regc      <= COLOR;
      end
      if (state == SEED) regc <= CELL_RDATA;
      if (state == RECOLOR || state == SWEEP_END) changed <= 1'b0;
      if (take) begin
        mask[r][c] <= 1'b1;
        count      <= count == CMAX ? count : count + 10'd1;
        changed    <= 1'b1;
      end
      if (state == FINISH) begin
        grown_q <= grown_now;
        won_q   <= won_now;
      end
    end
  end
endmodule

// File: tb/tb_flood_sequencer.sv
// tb_flood_sequencer: directed scenarios for flood_sequencer against a behavioural cell RAM
module tb_flood_sequencer;
  logic       CLOCK = 1'b0, RESET_N = 1'b0, INIT = 1'b0, START = 1'b0;
  logic [2:0] COLOR = '0;
  logic [4:0] SIZE = '0;
  logic [9:0] CELL_ADDR, FLOOD_COUNT;
  logic [2:0] CELL_RDATA, CELL_WDATA;
  logic       CELL_WE, BUSY, DONE, GROWN, WON;
  logic       ld_en = 1'b0, ld_clr = 1'b0;
  logic [9:0] ld_addr = '0;
  logic [2:0] ld_data = '0;
  logic [2:0] mem [1024];
  logic [9:0] wr_addr [$];
  logic [2:0] wr_data [$];
  int chk_cnt = 0, pass_cnt = 0, we_cnt = 0, done_cnt = 0, max_r = 0, max_c = 0;

  flood_sequencer dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .INIT(INIT), .START(START), .COLOR(COLOR), .SIZE(SIZE),
    .CELL_ADDR(CELL_ADDR), .CELL_RDATA(CELL_RDATA), .CELL_WE(CELL_WE), .CELL_WDATA(CELL_WDATA),
    .BUSY(BUSY), .DONE(DONE), .GROWN(GROWN), .WON(WON), .FLOOD_COUNT(FLOOD_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  // Cell RAM with one-cycle read latency plus a bench-side load port
  always @(posedge CLOCK) begin
    if (ld_clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
    else if (ld_en) mem[ld_addr] <= ld_data;
    else if (CELL_WE) mem[CELL_ADDR] <= CELL_WDATA;
    CELL_RDATA <= mem[CELL_ADDR];
  end

  // Observe writes, DONE pulses and the address range visited while busy
  always @(negedge CLOCK) begin
    if (CELL_WE) begin
      we_cnt++;
      wr_addr.push_back(CELL_ADDR);
      wr_data.push_back(CELL_WDATA);
    end
    if (DONE) done_cnt++;
    if (BUSY && int'(CELL_ADDR[9:5]) > max_r) max_r = int'(CELL_ADDR[9:5]);
    if (BUSY && int'(CELL_ADDR[4:0]) > max_c) max_c = int'(CELL_ADDR[4:0]);
  end

  task automatic put(input logic [9:0] a, input logic [2:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge CLOCK);
    ld_en = 1'b0;
  endtask

  task automatic clear_mem();
    ld_clr = 1'b1;
    @(negedge CLOCK);
    ld_clr = 1'b0;
  endtask

  // Pulse cycle is cycle 1; returns at the negedge of cycle 2
  task automatic issue(input logic i, input logic s, input logic [2:0] col, input logic [4:0] sz);
    @(negedge CLOCK);
    INIT = i; START = s; COLOR = col; SIZE = sz;
    @(negedge CLOCK);
    INIT = 1'b0; START = 1'b0;
  endtask

  task automatic wait_done(input int lat0, input int limit, output int lat);
    lat = lat0;
    while (!DONE && lat < limit) begin
      @(negedge CLOCK);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK);
    chk_cnt++; if (BUSY !== 1'b0 || DONE !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", BUSY, DONE); else pass_cnt++;
    chk_cnt++; if (CELL_WE !== 1'b0 || CELL_ADDR !== 10'd0 || CELL_WDATA !== 3'd0) $display("FAIL reset_ram_if: got we=%b addr=%h wd=%0d want 0", CELL_WE, CELL_ADDR, CELL_WDATA); else pass_cnt++;
    chk_cnt++; if (FLOOD_COUNT !== 10'd0) $display("FAIL reset_count: got %0d want 0", FLOOD_COUNT); else pass_cnt++;
    chk_cnt++; if (GROWN !== 1'b0 || WON !== 1'b0) $display("FAIL reset_flags: got grown=%b won=%b want 0", GROWN, WON); else pass_cnt++;
    RESET_N = 1'b1;
    @(negedge CLOCK);
  endtask

  task automatic test_init_small();
    int lat, w0;
    clear_mem();
    put(10'h000, 3'd1); put(10'h001, 3'd1); put(10'h020, 3'd2); put(10'h021, 3'd3);
    w0 = we_cnt;
    issue(1'b1, 1'b0, 3'd0, 5'd2);
    wait_done(2, 200, lat);
    chk_cnt++; if (lat !== 21) $display("FAIL init2_latency: got %0d want 21", lat); else pass_cnt++;
    chk_cnt++; if (FLOOD_COUNT !== 10'd2) $display("FAIL init2_count: got %0d want 2", FLOOD_COUNT); else pass_cnt++;
    chk_cnt++; if (WON !== 1'b0 || GROWN !== 1'b0) $display("FAIL init2_flags: got won=%b grown=%b want 0 0", WON, GROWN); else pass_cnt++;
    chk_cnt++; if (we_cnt !== w0) $display("FAIL init2_writes: got %0d writes want 0", we_cnt - w0); else pass_cnt++;
  endtask

  task automatic test_move_small();
    int lat;
    wr_addr.delete(); wr_data.delete();
    issue(1'b0, 1'b1, 3'd2, 5'd2);
    chk_cnt++; if (BUSY !== 1'b1) $display("FAIL move2_busy: got %b want 1", BUSY); else pass_cnt++;
    wait_done(2, 200, lat);
    chk_cnt++; if (lat !== 24) $display("FAIL move2_latency: got %0d want 24", lat); else pass_cnt++;
    chk_cnt++; if (wr_addr.size() != 2 || wr_addr[0] !== 10'h000 || wr_addr[1] !== 10'h001 || wr_data[0] !== 3'd2 || wr_data[1] !== 3'd2)
      $display("FAIL move2_writes: got %0d writes (first addr %h) want 2 writes of 2 at 000,001", wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 10'h3ff); else pass_cnt++;
    chk_cnt++; if (FLOOD_COUNT !== 10'd3) $display("FAIL move2_count: got %0d want 3", FLOOD_COUNT); else pass_cnt++;
    chk_cnt++; if (GROWN !== 1'b1 || WON !== 1'b0) $display("FAIL move2_flags: got grown=%b won=%b want 1 0", GROWN, WON); else pass_cnt++;
    issue(1'b0, 1'b1, 3'd3, 5'd2);
    wait_done(2, 200, lat);
    chk_cnt++; if (lat !== 24) $display("FAIL move3_latency: got %0d want 24", lat); else pass_cnt++;
    chk_cnt++; if (FLOOD_COUNT !== 10'd4) $display("FAIL move3_count: got %0d want 4", FLOOD_COUNT); else pass_cnt++;
    chk_cnt++; if (WON !== 1'b1 || GROWN !== 1'b1) $display("FAIL move3_flags: got won=%b grown=%b want 1 1", WON, GROWN); else pass_cnt++;
    @(negedge CLOCK);
    chk_cnt++; if (WON !== 1'b1) $display("FAIL move3_won_hold: got %b want 1", WON); else pass_cnt++;
  endtask

  task automatic test_same_color();
    int lat, w0;
    w0 = we_cnt;
    issue(1'b0, 1'b1, 3'd3, 5'd2);
    wait_done(2, 50, lat);
    chk_cnt++; if (lat !== 2) $display("FAIL same_latency: got %0d want 2", lat); else pass_cnt++;
    chk_cnt++; if (GROWN !== 1'b0) $display("FAIL same_grown: got %b want 0", GROWN); else pass_cnt++;
    chk_cnt++; if (FLOOD_COUNT !== 10'd4) $display("FAIL same_count: got %0d want 4", FLOOD_COUNT); else pass_cnt++;
    @(negedge CLOCK);
    chk_cnt++; if (we_cnt !== w0) $display("FAIL same_writes: got %0d writes want 0", we_cnt - w0); else pass_cnt++;
  endtask

  task automatic test_serpentine();
    int lat;
    logic [2:0] board [16] = '{3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1,
                               3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    logic [9:0] exp_w [11] = '{10'h000, 10'h002, 10'h003, 10'h020, 10'h023, 10'h040,
                               10'h043, 10'h060, 10'h061, 10'h062, 10'h063};
    logic bad;
    clear_mem();
    for (int i = 0; i < 16; i++) put({5'(i / 4), 5'(i % 4)}, board[i]);
    issue(1'b1, 1'b0, 3'd0, 5'd4);
    wait_done(2, 1000, lat);
    chk_cnt++; if (lat !== 201) $display("FAIL serp_init_latency: got %0d want 201", lat); else pass_cnt++;
    chk_cnt++; if (FLOOD_COUNT !== 10'd11) $display("FAIL serp_init_count: got %0d want 11", FLOOD_COUNT); else pass_cnt++;
    chk_cnt++; if (WON !== 1'b0 || GROWN !== 1'b0) $display("FAIL serp_init_flags: got won=%b grown=%b want 0 0", WON, GROWN); else pass_cnt++;
    wr_addr.delete(); wr_data.delete();
    issue(1'b0, 1'b1, 3'd5, 5'd4);
    wait_done(2, 1000, lat);
    chk_cnt++; if (lat !== 51) $display("FAIL serp_move_latency: got %0d want 51", lat); else pass_cnt++;
    bad = wr_addr.size() != 11;
    for (int i = 0; i < 11 && !bad; i++) bad = wr_addr[i] !== exp_w[i] || wr_data[i] !== 3'd5;
    chk_cnt++; if (bad) $display("FAIL serp_mask: got %0d writes want the 11 reachable cells written with 5", wr_addr.size()); else pass_cnt++;
    chk_cnt++; if (GROWN !== 1'b0 || FLOOD_COUNT !== 10'd11) $display("FAIL serp_move_result: got grown=%b count=%0d want 0 11", GROWN, FLOOD_COUNT); else pass_cnt++;
  endtask

  task automatic test_busy_and_collision();
    int lat, w0, d0;
    clear_mem();
    put(10'h000, 3'd4);
    w0 = we_cnt; d0 = done_cnt; max_r = 0; max_c = 0;
    issue(1'b1, 1'b1, 3'd2, 5'd31);
    @(negedge CLOCK);
    START = 1'b1; COLOR = 3'd2; SIZE = 5'd26;
    @(negedge CLOCK);
    START = 1'b0;
    wait_done(4, 3000, lat);
    chk_cnt++; if (lat !== 1356) $display("FAIL collide_latency: got %0d want 1356", lat); else pass_cnt++;
    chk_cnt++; if (FLOOD_COUNT !== 10'd1 || GROWN !== 1'b0) $display("FAIL collide_result: got count=%0d grown=%b want 1 0", FLOOD_COUNT, GROWN); else pass_cnt++;
    repeat (10) @(negedge CLOCK);
    chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL busy_done_pulses: got %0d want 1", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (we_cnt !== w0) $display("FAIL collide_writes: got %0d writes want 0", we_cnt - w0); else pass_cnt++;
    chk_cnt++; if (max_r !== 25 || max_c !== 25) $display("FAIL clamp_max_addr: got row %0d col %0d want 25 25", max_r, max_c); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    issue(1'b0, 1'b1, 3'd6, 5'd26);
    repeat (690) @(negedge CLOCK);
    chk_cnt++; if (BUSY !== 1'b1 || CELL_WDATA !== 3'd6 || FLOOD_COUNT !== 10'd1) $display("FAIL midgrow_pre: got busy=%b wd=%0d count=%0d want 1 6 1", BUSY, CELL_WDATA, FLOOD_COUNT); else pass_cnt++;
    @(posedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    chk_cnt++; if ({CELL_ADDR, CELL_WE, CELL_WDATA, BUSY, DONE, GROWN, WON, FLOOD_COUNT} !== '0)
      $display("FAIL midgrow_async: got addr=%h we=%b wd=%0d busy=%b done=%b grown=%b won=%b count=%0d want all 0",
               CELL_ADDR, CELL_WE, CELL_WDATA, BUSY, DONE, GROWN, WON, FLOOD_COUNT); else pass_cnt++;
    w0 = we_cnt; d0 = done_cnt;
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLOCK);
    chk_cnt++; if (we_cnt !== w0) $display("FAIL midgrow_no_write: got %0d writes want 0", we_cnt - w0); else pass_cnt++;
    chk_cnt++; if (BUSY !== 1'b0 || done_cnt !== d0 || FLOOD_COUNT !== 10'd0) $display("FAIL midgrow_after: got busy=%b dones=%0d count=%0d want 0 0 0", BUSY, done_cnt - d0, FLOOD_COUNT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_init_small();
    test_move_small();
    test_same_color();
    test_serpentine();
    test_busy_and_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/flood_sequencer.md
# flood_sequencer

Sequences one flood-fill move over the game board held in the shared cell RAM. It keeps the 26x26 "flooded" mask internally, recolours the flooded region on a move, then sweeps the board repeatedly to absorb matching neighbours until nothing changes. It sits between the selector's colour-select handshake and the board storage that the VGA path reads. It reports move completion, region growth, flooded-cell count and the win condition.

## Interface

Parameters:
- MAX_SIZE, 26: largest board edge; mask is MAX_SIZE x MAX_SIZE bits.
- COLOR_W, 3: bits per cell colour.

Ports:
- CLOCK, in, 1: single clock for all logic.
- RESET_N, in, 1: reset; asynchronous, active-low.
- INIT, in, 1: one-cycle pulse; a new board has been loaded, so seed the region at (0,0).
- START, in, 1: one-cycle pulse; perform a move with COLOR.
- COLOR, in, COLOR_W: new colour, sampled on START.
- SIZE, in, 5: board edge, sampled on INIT/START; values below 2 are treated as 2, above MAX_SIZE as MAX_SIZE.
- CELL_ADDR, out, 10: cell RAM address {row[4:0], col[4:0]}.
- CELL_RDATA, in, COLOR_W: RAM read data, valid one cycle after CELL_ADDR.
- CELL_WE, out, 1: RAM write enable.
- CELL_WDATA, out, COLOR_W: RAM write data.
- BUSY, out, 1: high from the accepted INIT/START until DONE.
- DONE, out, 1: one-cycle completion pulse.
- GROWN, out, 1: latched at DONE; the last START increased FLOOD_COUNT.
- WON, out, 1: level; every cell inside SIZE x SIZE is flooded.
- FLOOD_COUNT, out, 10: number of flooded cells.

## Operation

- States: IDLE, SEED, RECOLOR, GROW_ADDR, GROW_EVAL, SWEEP_END, FINISH.
- IDLE, on INIT:
  - Clear the mask, set bit (0,0), FLOOD_COUNT=1.
  - Go to SEED, which reads cell (0,0) into the region colour register REGC.
  - Then go to GROW_ADDR at (0,0).
- IDLE, on START:
  - Latch COLOR into NEWC and record OLD_COUNT.
  - If NEWC==REGC, go straight to FINISH with GROWN=0 and perform no RAM writes.
  - Otherwise set REGC=NEWC and go to RECOLOR.
- RECOLOR:
  - Step row-major over (r,c), r,c < SIZE, at one cell per cycle.
  - CELL_WE=1 with CELL_WDATA=NEWC exactly on flooded cells.
  - After the last cell, go to GROW_ADDR at (0,0) and clear the changed flag.
- GROW_ADDR / GROW_EVAL (two cycles per cell):
  - GROW_ADDR drives the address.
  - GROW_EVAL takes the cell if it is unflooded, CELL_RDATA==REGC, and any in-bounds 4-neighbour mask bit is set.
  - Taking a cell sets its mask bit, increments FLOOD_COUNT and sets the changed flag.
  - Neighbours outside SIZE are ignored; row/column 0 have no up/left neighbour.
- SWEEP_END: if changed, restart the sweep at (0,0); otherwise go to FINISH.
- FINISH:
  - Pulse DONE and drop BUSY.
  - GROWN = (FLOOD_COUNT > OLD_COUNT) for START; GROWN=0 for INIT.
  - WON = (FLOOD_COUNT == SIZE*SIZE).
  - Return to IDLE.
- START or INIT while BUSY: ignored. START and INIT in the same IDLE cycle: INIT wins.
- CELL_WE is only ever high in RECOLOR. Sequencer writes do not alter the mask.

## Timing

- Reset values: state IDLE; CELL_ADDR=0, CELL_WE=0, CELL_WDATA=0; BUSY=0, DONE=0, GROWN=0, WON=0, FLOOD_COUNT=0; mask all zero; REGC=0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). No further write occurs and the mask is lost.
- BUSY rises the cycle after an accepted pulse.
- Move latency with N=SIZE*SIZE and k sweeps (k>=1, the final sweep having no change):
  - Move: 1 + N (RECOLOR) + k*(2N+1) + 1 cycles to the DONE pulse.
  - INIT: 2 + k*(2N+1) + 1 cycles to the DONE pulse.
- Same-colour START: DONE two cycles after START.
- FLOOD_COUNT is a 10-bit count, saturating at 676 and never wrapping. WON is combinationally consistent with FLOOD_COUNT only at FINISH and holds until the next accepted pulse.

## Test plan

- Reset: pulse RESET_N low mid-GROW -> every output 0 within the same cycle, CELL_WE never rises afterwards, BUSY=0.
- INIT on SIZE=2, board [1,1;2,3] -> DONE pulse, FLOOD_COUNT=2, WON=0, GROWN=0, no CELL_WE activity.
- Then START COLOR=2 -> writes of 2 to addrs 0x000 and 0x001 only; FLOOD_COUNT=3, GROWN=1, WON=0. Then START COLOR=3 -> FLOOD_COUNT=4, WON=1.
- SIZE=4 serpentine board whose path needs upward/leftward propagation -> k>=3 sweeps, DONE at the cycle count given by the latency formula, and the mask exactly equals the reachable set.
- START with COLOR equal to REGC -> DONE two cycles later, no writes, GROWN=0, FLOOD_COUNT unchanged.
- START during BUSY and simultaneous START+INIT -> the busy START is ignored (no extra DONE); the simultaneous pulse performs INIT only; SIZE=31 behaves as 26 (max address row 25, column 25).
